pipe_hazard_ctrl: RTL and testbench

//  Central sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
//  - Owns every stage-register enable, flush and bubble, plus PC-enable and PC-redirect.
//  - Arbitrates three stall sources with a fixed priority:
//    MEM-wait (LSU not ready) > taken branch/jump in EX > load-use hazard in ID.
//  - Replaces the opcode-only stall decode. Sits beside the forwarding unit.

---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/load_use_detect.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the RV32I pipeline hazard sequencer: FSM states, control bundle, constants.
package pipe_ctrl_pkg;

  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic pc_redirect;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_bubble;
    logic ex_mem_en;
    logic mem_wb_en;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_RUN = '{pc_en: 1'b1, pc_redirect: 1'b0, if_id_en: 1'b1, if_id_flush: 1'b0,
                                    id_ex_en: 1'b1, id_ex_bubble: 1'b0, ex_mem_en: 1'b1, mem_wb_en: 1'b1};
  localparam pipe_ctl_t CTL_BR  = '{pc_en: 1'b1, pc_redirect: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                                    id_ex_en: 1'b1, id_ex_bubble: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1};
  localparam pipe_ctl_t CTL_LU  = '{pc_en: 1'b0, pc_redirect: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                    id_ex_en: 1'b1, id_ex_bubble: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1};
  localparam pipe_ctl_t CTL_FRZ = '{pc_en: 1'b0, pc_redirect: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                    id_ex_en: 1'b0, id_ex_bubble: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0};
  localparam pipe_ctl_t CTL_RST = '{pc_en: 1'b0, pc_redirect: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
                                    id_ex_en: 1'b0, id_ex_bubble: 1'b1, ex_mem_en: 1'b0, mem_wb_en: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect between the load in EX and the instruction in ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rd_wren,
  input  logic              ex_is_load,
  output logic              luh
);

  logic rd_live;
  logic hit1;
  logic hit2;

  assign rd_live = ex_is_load & ex_rd_wren & (ex_rd != REG_AW'(REG_ZERO));
  assign hit1    = id_use_rs1 & (id_rs1 == ex_rd);
  assign hit2    = id_use_rs2 & (id_rs2 == ex_rd);
  assign luh     = rd_live & (hit1 | hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes/bubbles with MEM-wait > branch > load-use priority.
// Define HAZ_PERF_CNT_EN to build the stall_cnt/flush_cnt performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned LOAD_STALL_C = 1,
  parameter int unsigned MEM_TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rd_wren,
  input  logic              ex_is_load,
  input  logic              ex_br_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              pc_redirect,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_bubble,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              mem_err,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  state_t    state;
  logic [2:0] lcnt;
  logic [7:0] wcnt;
  logic       luh;
  logic       busy;
  logic       timeout;
  logic       hold;
  logic       ld_act;
  pipe_ctl_t  ctl;

  load_use_detect #(.REG_AW(REG_AW)) u_luh (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_rd_wren (ex_rd_wren),
    .ex_is_load (ex_is_load),
    .luh        (luh)
  );

  assign busy    = mem_req & ~mem_ready;
  // The timeout cycle is handled exactly like a mem_ready cycle so the pipeline resumes at once.
  assign timeout = busy && (state == MEMWAIT) && (wcnt == 8'(MEM_TIMEOUT - 1));
  assign hold    = busy & ~timeout;
  assign ld_act  = luh | (state == LDSTALL);
  assign mem_err = ~rst & timeout;

  always_comb begin
    ctl = CTL_RUN;
    if (rst)              ctl = CTL_RST;
    else if (hold)        ctl = CTL_FRZ;
    else if (ex_br_taken) ctl = CTL_BR;
    else if (ld_act)      ctl = CTL_LU;
  end

  assign pc_en        = ctl.pc_en;
  assign pc_redirect  = ctl.pc_redirect;
  assign if_id_en     = ctl.if_id_en;
  assign if_id_flush  = ctl.if_id_flush;
  assign id_ex_en     = ctl.id_ex_en;
  assign id_ex_bubble = ctl.id_ex_bubble;
  assign ex_mem_en    = ctl.ex_mem_en;
  assign mem_wb_en    = ctl.mem_wb_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      lcnt  <= '0;
      wcnt  <= '0;
    end else if (hold) begin
      state <= MEMWAIT;
      wcnt  <= wcnt + 8'd1;
      lcnt  <= '0;
    end else begin
      wcnt <= '0;
      if (ex_br_taken) begin
        state <= RUN;
        lcnt  <= '0;
      end else if (state == LDSTALL) begin
        lcnt  <= lcnt - 3'd1;
        state <= (lcnt == 3'd1) ? RUN : LDSTALL;
      end else if (luh) begin
        lcnt  <= 3'(LOAD_STALL_C - 1);
        state <= (LOAD_STALL_C > 1) ? LDSTALL : RUN;
      end else begin
        state <= RUN;
        lcnt  <= '0;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!ctl.pc_en && stall_q != '1)      stall_q <= stall_q + 32'd1;
      if (ctl.pc_redirect && flush_q != '1) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: one instance with one bubble, one with three bubbles.
module tb_pipe_hazard_ctrl;

  localparam logic [7:0] RN = 8'hAB;
  localparam logic [7:0] BR = 8'hFF;
  localparam logic [7:0] LU = 8'h0F;
  localparam logic [7:0] FZ = 8'h00;
  localparam logic [7:0] RS = 8'h14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_rd_wren = 1'b0, ex_is_load = 1'b0;
  logic       ex_br_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;

  logic [7:0]  ctl_a, ctl_b;
  logic        err_a, err_b;
  logic [31:0] st_a, fl_a, st_b, fl_b;

  typedef struct {
    logic [7:0]  ca, cb;
    logic        err;
    logic [31:0] sa, fa, sb, fb;
  } exp_t;

  exp_t        q[$];
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  logic [31:0] m_sa = '0, m_fa = '0, m_sb = '0, m_fb = '0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_STALL_C(1), .MEM_TIMEOUT(16)) u_dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_rd_wren(ex_rd_wren), .ex_is_load(ex_is_load),
    .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(ctl_a[7]), .pc_redirect(ctl_a[6]), .if_id_en(ctl_a[5]), .if_id_flush(ctl_a[4]),
    .id_ex_en(ctl_a[3]), .id_ex_bubble(ctl_a[2]), .ex_mem_en(ctl_a[1]), .mem_wb_en(ctl_a[0]),
    .mem_err(err_a), .stall_cnt(st_a), .flush_cnt(fl_a)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_STALL_C(3), .MEM_TIMEOUT(16)) u_dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_rd_wren(ex_rd_wren), .ex_is_load(ex_is_load),
    .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(ctl_b[7]), .pc_redirect(ctl_b[6]), .if_id_en(ctl_b[5]), .if_id_flush(ctl_b[4]),
    .id_ex_en(ctl_b[3]), .id_ex_bubble(ctl_b[2]), .ex_mem_en(ctl_b[1]), .mem_wb_en(ctl_b[0]),
    .mem_err(err_b), .stall_cnt(st_b), .flush_cnt(fl_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drives one cycle of inputs right after the rising edge and queues the hand-computed response.
  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd, input logic wren,
                      input logic ld, input logic br, input logic mreq, input logic mrdy,
                      input logic [7:0] ea, input logic [7:0] eb, input logic eerr);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_rd_wren = wren; ex_is_load = ld; ex_br_taken = br;
    mem_req = mreq; mem_ready = mrdy;
    if (r) begin
      m_sa = '0; m_fa = '0; m_sb = '0; m_fb = '0;
    end
    e.ca = ea; e.cb = eb; e.err = eerr;
`ifdef HAZ_PERF_CNT_EN
    e.sa = m_sa; e.fa = m_fa; e.sb = m_sb; e.fb = m_fb;
`else
    e.sa = '0; e.fa = '0; e.sb = '0; e.fb = '0;
`endif
    q.push_back(e);
    if (!r) begin
      if (!ea[7]) m_sa = m_sa + 1;
      if (ea[6])  m_fa = m_fa + 1;
      if (!eb[7]) m_sb = m_sb + 1;
      if (eb[6])  m_fb = m_fb + 1;
    end
  endtask

  task automatic idle(input logic [7:0] ea, input logic [7:0] eb);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, ea, eb, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ctl_a", 32'(ctl_a), 32'(e.ca));
      chk("ctl_b", 32'(ctl_b), 32'(e.cb));
      chk("mem_err_a", 32'(err_a), 32'(e.err));
      chk("mem_err_b", 32'(err_b), 32'(e.err));
      chk("stall_cnt_a", st_a, e.sa);
      chk("flush_cnt_a", fl_a, e.fa);
      chk("stall_cnt_b", st_b, e.sb);
      chk("flush_cnt_b", fl_b, e.fb);
    end
  end

  initial begin
    // reset values
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, RS, RS, 0);
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, RS, RS, 0);
    idle(RN, RN);
    // load-use on rs1: A one bubble, B three
    step(0, 5'd5, 5'd1, 1, 1, 5'd5, 1, 1, 0, 0, 0, LU, LU, 0);
    step(0, 5'd5, 5'd1, 1, 1, 5'd0, 0, 0, 0, 0, 0, RN, LU, 0);
    step(0, 5'd5, 5'd1, 1, 1, 5'd0, 0, 0, 0, 0, 0, RN, LU, 0);
    step(0, 5'd5, 5'd1, 1, 1, 5'd0, 0, 0, 0, 0, 0, RN, RN, 0);
    // index match gated by use flags, not-load, no-write, and x0
    step(0, 5'd7, 5'd3, 0, 1, 5'd7, 1, 1, 0, 0, 0, RN, RN, 0);
    step(0, 5'd0, 5'd2, 1, 0, 5'd0, 1, 1, 0, 0, 0, RN, RN, 0);
    step(0, 5'd5, 5'd2, 1, 0, 5'd5, 1, 0, 0, 0, 0, RN, RN, 0);
    step(0, 5'd5, 5'd2, 1, 0, 5'd5, 0, 1, 0, 0, 0, RN, RN, 0);
    // load-use on rs2, then a branch aborts B's remaining bubbles
    step(0, 5'd3, 5'd7, 0, 1, 5'd7, 1, 1, 0, 0, 0, LU, LU, 0);
    step(0, 5'd3, 5'd7, 0, 1, 5'd0, 0, 0, 1, 0, 0, BR, BR, 0);
    idle(RN, RN);
    // branch coinciding with load-use
    step(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 1, 0, 0, BR, BR, 0);
    idle(RN, RN);
    // four-cycle MEM wait
    repeat (4) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, FZ, FZ, 0);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, RN, RN, 0);
    idle(RN, RN);
    // branch held during a freeze redirects once afterwards
    repeat (2) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, FZ, FZ, 0);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 1, BR, BR, 0);
    idle(RN, RN);
    // load-use held during a freeze resolves at normal priority afterwards
    step(0, 5'd9, 5'd0, 1, 0, 5'd9, 1, 1, 0, 1, 0, FZ, FZ, 0);
    step(0, 5'd9, 5'd0, 1, 0, 5'd9, 1, 1, 0, 1, 1, LU, LU, 0);
    idle(RN, LU);
    idle(RN, LU);
    idle(RN, RN);
    // timeout: wait cycle 16 pulses mem_err and releases
    repeat (15) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, FZ, FZ, 0);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, RN, RN, 1);
    idle(RN, RN);
    // reset during MEMWAIT
    repeat (3) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, FZ, FZ, 0);
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, RS, RS, 0);
    idle(RN, RN);
    // reset during LDSTALL
    step(0, 5'd4, 5'd0, 1, 0, 5'd4, 1, 1, 0, 0, 0, LU, LU, 0);
    step(1, 5'd4, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0, 0, RS, RS, 0);
    step(0, 5'd4, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0, 0, RN, RN, 0);
    idle(RN, RN);

    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
